// File: rtl/cam_awb_pkg.sv
// cam_awb_pkg: shared constants, Bayer lane map and gain stepping
// helper for the auto-white-balance controller.
package cam_awb_pkg;

    localparam logic [2:0] GAIN_UNITY = 3'd4;
    localparam logic [2:0] GAIN_MAX   = 3'd7;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_SRCH_R = 3'd2;
    localparam logic [2:0] S_SRCH_B = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    typedef enum logic [1:0] {
        COL_R = 2'd0,
        COL_G = 2'd1,
        COL_B = 2'd2
    } col_e;

    // Even lines carry G,R,G,R on lanes 3..0; odd lines B,G,B,G.
    function automatic col_e lane_col(input logic phase, input logic [1:0] lane);
        if (!phase) begin
            return lane[0] ? COL_G : COL_R;
        end
        return lane[0] ? COL_B : COL_G;
    endfunction

    function automatic logic [2:0] next_gain(input logic [2:0] cur,
                                             input logic [2:0] tgt,
                                             input logic       lim);
        if (!lim || cur == tgt) begin
            return tgt;
        end
        return (tgt > cur) ? cur + 3'd1 : cur - 3'd1;
    endfunction

endpackage

// File: rtl/cam_awb_gain_search.sv
// cam_awb_gain_search: finds the largest k in 7..1 with num >= (2k-1)*den,
// one shift-add compare per clock; result on the seventh step.
import cam_awb_pkg::*;

module cam_awb_gain_search #(
    parameter int ACC_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic [ACC_W+1:0] num_i,
    input  logic [ACC_W-1:0] den_i,
    output logic             done_o,
    output logic [2:0]       code_o
);

    logic [2:0]       k_q;
    logic [2:0]       code_q;
    logic [2:0]       code_d;
    logic [3:0]       mult;
    logic [ACC_W+3:0] prod;
    logic             hit;

    assign mult = {k_q, 1'b0} - 4'd1;

    always_comb begin
        prod = '0;
        for (int b = 0; b < 4; b++) begin
            if (mult[b]) begin
                prod = prod + ({4'b0000, den_i} << b);
            end
        end
    end

    // k is never 0 while stepping, so code 0 doubles as "nothing found yet".
    assign hit    = {2'b00, num_i} >= prod;
    assign code_d = (code_q == 3'd0 && hit) ? k_q : code_q;
    assign done_o = step_i && (k_q == 3'd1);
    assign code_o = code_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_q    <= GAIN_MAX;
            code_q <= 3'd0;
        end else if (clr_i || done_o) begin
            k_q    <= GAIN_MAX;
            code_q <= 3'd0;
        end else if (step_i) begin
            k_q    <= k_q - 3'd1;
            code_q <= code_d;
        end
    end

endmodule

// File: rtl/cam_awb_gain_ctrl.sv
// cam_awb_gain_ctrl: per-frame Bayer colour sums from a 4PPC raw stream,
// then red/blue gain codes relative to green for cam_rgb_gain.
import cam_awb_pkg::*;

module cam_awb_gain_ctrl #(
    parameter int P_DEPTH      = 10,
    parameter int PW           = 40,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int P_STEP_LIMIT = 1
) (
    input  logic          i_pclk,
    input  logic          i_arstn,
    input  logic          i_vs,
    input  logic          i_valid,
    input  logic [PW-1:0] i_data,
    input  logic          i_awb_en,
    output logic [2:0]    o_red_gain,
    output logic [2:0]    o_green_gain,
    output logic [2:0]    o_blue_gain,
    output logic          o_gain_update,
    output logic          o_busy
);

    localparam int ACC_W = P_DEPTH + $clog2(FRAME_WIDTH * FRAME_HEIGHT / 2);
    localparam int BEATS = FRAME_WIDTH / 4;
    localparam int BW    = $clog2(BEATS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic             vs_q;
    logic             frame_end;
    logic             start;
    logic             phase_q, phase_d, phase_base;
    logic [BW-1:0]    beat_q, beat_d, beat_base;
    logic [ACC_W-1:0] acc_r_q, acc_g_q, acc_b_q;
    logic [ACC_W-1:0] acc_r_d, acc_g_d, acc_b_d;
    logic [ACC_W-1:0] add_r, add_g, add_b;
    logic [ACC_W-1:0] snap_r_q, snap_g_q, snap_b_q;
    logic [P_DEPTH-1:0] px;
    col_e             col;
    logic [2:0]       state_q, state_d;
    logic [2:0]       tgt_r_q, tgt_b_q;
    logic [2:0]       gain_r_q, gain_b_q;
    logic             srch_done;
    logic [2:0]       srch_code;

    assign frame_end = vs_q & ~i_vs;
    assign start     = frame_end & ((state_q == S_IDLE) | (state_q == S_UPDATE));

    // The beat on the frame-end cycle already belongs to the next frame.
    always_comb begin
        phase_base = frame_end ? 1'b0 : phase_q;
        beat_base  = frame_end ? '0 : beat_q;
        add_r = '0;
        add_g = '0;
        add_b = '0;
        px    = '0;
        col   = COL_G;
        for (int l = 0; l < 4; l++) begin
            px  = i_data[l*P_DEPTH +: P_DEPTH];
            col = lane_col(phase_base, 2'(l));
            unique case (col)
                COL_R:   add_r = add_r + ACC_W'(px);
                COL_G:   add_g = add_g + ACC_W'(px);
                default: add_b = add_b + ACC_W'(px);
            endcase
        end
        acc_r_d = (frame_end ? '0 : acc_r_q) + (i_valid ? add_r : '0);
        acc_g_d = (frame_end ? '0 : acc_g_q) + (i_valid ? add_g : '0);
        acc_b_d = (frame_end ? '0 : acc_b_q) + (i_valid ? add_b : '0);
        beat_d  = beat_base;
        phase_d = phase_base;
        if (i_valid) begin
            if (beat_base == LAST_BEAT) begin
                beat_d  = '0;
                phase_d = ~phase_base;
            end else begin
                beat_d = beat_base + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_LATCH;
            S_LATCH:  state_d = S_SRCH_R;
            S_SRCH_R: if (srch_done) state_d = S_SRCH_B;
            S_SRCH_B: if (srch_done) state_d = S_UPDATE;
            S_UPDATE: state_d = start ? S_LATCH : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    cam_awb_gain_search #(
        .ACC_W (ACC_W)
    ) u_search (
        .clk_i  (i_pclk),
        .rst_ni (i_arstn),
        .clr_i  (state_q == S_LATCH),
        .step_i ((state_q == S_SRCH_R) || (state_q == S_SRCH_B)),
        .num_i  ({snap_g_q, 2'b00}),
        .den_i  ((state_q == S_SRCH_B) ? snap_b_q : snap_r_q),
        .done_o (srch_done),
        .code_o (srch_code)
    );

    always_ff @(posedge i_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            vs_q     <= 1'b0;
            phase_q  <= 1'b0;
            beat_q   <= '0;
            acc_r_q  <= '0;
            acc_g_q  <= '0;
            acc_b_q  <= '0;
            snap_r_q <= '0;
            snap_g_q <= '0;
            snap_b_q <= '0;
            state_q  <= S_IDLE;
            tgt_r_q  <= GAIN_UNITY;
            tgt_b_q  <= GAIN_UNITY;
            gain_r_q <= GAIN_UNITY;
            gain_b_q <= GAIN_UNITY;
        end else begin
            vs_q    <= i_vs;
            phase_q <= phase_d;
            beat_q  <= beat_d;
            acc_r_q <= acc_r_d;
            acc_g_q <= acc_g_d;
            acc_b_q <= acc_b_d;
            state_q <= state_d;
            if (start) begin
                snap_r_q <= acc_r_q;
                snap_g_q <= acc_g_q;
                snap_b_q <= acc_b_q;
            end
            if (srch_done && state_q == S_SRCH_R) tgt_r_q <= srch_code;
            if (srch_done && state_q == S_SRCH_B) tgt_b_q <= srch_code;
            if (!i_awb_en) begin
                gain_r_q <= GAIN_UNITY;
                gain_b_q <= GAIN_UNITY;
            end else if (state_q == S_UPDATE) begin
                gain_r_q <= next_gain(gain_r_q, tgt_r_q, P_STEP_LIMIT != 0);
                gain_b_q <= next_gain(gain_b_q, tgt_b_q, P_STEP_LIMIT != 0);
            end
        end
    end

    assign o_red_gain    = gain_r_q;
    assign o_green_gain  = GAIN_UNITY;
    assign o_blue_gain   = gain_b_q;
    assign o_gain_update = (state_q == S_UPDATE);
    assign o_busy        = (state_q == S_LATCH) || (state_q == S_SRCH_R) ||
                           (state_q == S_SRCH_B);

endmodule

// File: tb/tb_cam_awb_gain_ctrl.sv
// tb_cam_awb_gain_ctrl: drives small frames into a jump-mode and a
// step-mode instance and compares gains with a frame-level reference.
module tb_cam_awb_gain_ctrl;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int BEATS = W / 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs;
    logic        valid;
    logic [39:0] data;
    logic        en;
    logic [2:0]  r0, gr0, b0, r1, gr1, b1;
    logic        upd0, busy0, upd1, busy1;

    int n_chk = 0;
    int n_err = 0;
    int m_r, m_g, m_b;
    int g0r, g0b, g1r, g1b;

    always #5 clk = ~clk;

    cam_awb_gain_ctrl #(
        .P_DEPTH(10), .PW(40), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .P_STEP_LIMIT(0)
    ) u0 (
        .i_pclk(clk), .i_arstn(rst_n), .i_vs(vs), .i_valid(valid),
        .i_data(data), .i_awb_en(en), .o_red_gain(r0), .o_green_gain(gr0),
        .o_blue_gain(b0), .o_gain_update(upd0), .o_busy(busy0)
    );

    cam_awb_gain_ctrl #(
        .P_DEPTH(10), .PW(40), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .P_STEP_LIMIT(1)
    ) u1 (
        .i_pclk(clk), .i_arstn(rst_n), .i_vs(vs), .i_valid(valid),
        .i_data(data), .i_awb_en(en), .o_red_gain(r1), .o_green_gain(gr1),
        .o_blue_gain(b1), .o_gain_update(upd1), .o_busy(busy1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Colour by position: 0=R, 1=G, 2=B.
    function automatic int colour(input int line, input int lane);
        if (line % 2 == 0) return (lane % 2 == 0) ? 0 : 1;
        return (lane % 2 == 1) ? 2 : 1;
    endfunction

    function automatic int pix(input int mode, input int c);
        case (mode)
            0: return 512;
            1: return (c == 0) ? 256 : (c == 1) ? 512 : 1023;
            2: return (c == 0) ? 0 : 600;
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    // round(2G/X) clamped to 7; an empty channel asks for maximum gain.
    function automatic int target(input int g, input int x);
        int t;
        if (x == 0) return 7;
        t = (4 * g + x) / (2 * x);
        return (t > 7) ? 7 : t;
    endfunction

    task automatic build_beat(input int mode, input int line, output logic [39:0] d);
        int v;
        int c;
        d = '0;
        for (int l = 0; l < 4; l++) begin
            c = colour(line, l);
            v = pix(mode, c);
            d[l*10 +: 10] = 10'(v);
            if (c == 0) m_r += v;
            else if (c == 1) m_g += v;
            else m_b += v;
        end
    endtask

    task automatic apply(input int sr, input int sg, input int sb);
        int tr;
        int tb;
        tr = target(sg, sr);
        tb = target(sg, sb);
        if (en) begin
            g0r = tr;
            g0b = tb;
            g1r = g1r + int'(tr > g1r) - int'(tr < g1r);
            g1b = g1b + int'(tb > g1b) - int'(tb < g1b);
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, "/red0"}, int'(r0), g0r);
        chk({tag, "/blue0"}, int'(b0), g0b);
        chk({tag, "/red1"}, int'(r1), g1r);
        chk({tag, "/blue1"}, int'(b1), g1b);
        chk({tag, "/green"}, int'(gr0) * 8 + int'(gr1), 36);
    endtask

    task automatic send_frame(input int mode, input bit skip_first, input int drop_at);
        logic [39:0] d;
        int idx;
        vs = 1'b1;
        tick();
        for (int line = 0; line < H; line++) begin
            for (int b = 0; b < BEATS; b++) begin
                idx = line * BEATS + b;
                if (!(skip_first && idx == 0)) begin
                    if (idx == drop_at) begin
                        en = 1'b0;
                        tick();
                        g0r = 4; g0b = 4; g1r = 4; g1b = 4;
                        check_out("en_drop");
                    end
                    repeat ($urandom_range(0, 1)) tick();
                    build_beat(mode, line, d);
                    data  = d;
                    valid = 1'b1;
                    tick();
                    valid = 1'b0;
                end
            end
        end
    endtask

    task automatic finish_frame(input string tag, input bit carry, input int nmode);
        int sr, sg, sb, found;
        logic [39:0] d;
        sr = m_r; sg = m_g; sb = m_b;
        m_r = 0; m_g = 0; m_b = 0;
        vs = 1'b0;
        if (carry) begin
            build_beat(nmode, 0, d);
            data  = d;
            valid = 1'b1;
        end
        tick();
        valid = 1'b0;
        chk({tag, "/busy_latch"}, int'(busy0), 1);
        found = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (upd0) begin
                found = c;
                break;
            end
        end
        chk({tag, "/latency"}, found, 15);
        chk({tag, "/upd1"}, int'(upd1), 1);
        apply(sr, sg, sb);
        tick();
        chk({tag, "/pulse_off"}, int'(upd0), 0);
        chk({tag, "/busy_off"}, int'(busy1), 0);
        check_out(tag);
    endtask

    initial begin
        int sr, sg, sb, npulse, pos;
        logic [39:0] d;
        rst_n = 1'b0;
        vs = 1'b0; valid = 1'b0; data = '0; en = 1'b1;
        m_r = 0; m_g = 0; m_b = 0;
        g0r = 4; g0b = 4; g1r = 4; g1b = 4;
        repeat (3) tick();
        check_out("reset");
        chk("reset/upd", int'(upd0) + int'(upd1), 0);
        chk("reset/busy", int'(busy0) + int'(busy1), 0);
        rst_n = 1'b1;
        tick();

        for (int f = 0; f < 2; f++) begin
            send_frame(0, 1'b0, -1);
            finish_frame($sformatf("grey%0d", f), 1'b0, 0);
        end
        for (int f = 0; f < 4; f++) begin
            send_frame(1, 1'b0, -1);
            finish_frame($sformatf("rgb%0d", f), (f == 3), 2);
        end
        send_frame(2, 1'b1, -1);
        finish_frame("zero_red", 1'b0, 0);
        for (int f = 0; f < 3; f++) begin
            send_frame(3, 1'b0, -1);
            finish_frame($sformatf("rand%0d", f), 1'b0, 0);
        end

        // Short frame ending during the blue search is discarded.
        send_frame(1, 1'b0, -1);
        sr = m_r; sg = m_g; sb = m_b;
        m_r = 0; m_g = 0; m_b = 0;
        vs = 1'b0;
        tick();
        npulse = 0;
        pos = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) vs = 1'b1;
            if (c == 4 || c == 5) begin
                build_beat(3, 0, d);
                data  = d;
                valid = 1'b1;
            end else begin
                valid = 1'b0;
            end
            if (c == 9) begin
                vs = 1'b0;
                m_r = 0; m_g = 0; m_b = 0;
            end
            tick();
            if (upd0) begin
                npulse++;
                pos = c;
            end
        end
        chk("short/npulse", npulse, 1);
        chk("short/pos", pos, 15);
        apply(sr, sg, sb);
        check_out("short");
        send_frame(3, 1'b0, -1);
        finish_frame("after_short", 1'b0, 0);

        send_frame(1, 1'b0, -1);
        finish_frame("pre_en", 1'b0, 0);
        send_frame(1, 1'b0, 3);
        finish_frame("en_off", 1'b0, 0);
        en = 1'b1;
        send_frame(1, 1'b0, -1);
        finish_frame("en_on", 1'b0, 0);

        // Asynchronous reset while the red search is running.
        send_frame(3, 1'b0, -1);
        vs = 1'b0;
        tick();
        repeat (3) tick();
        chk("rst_mid/busy_before", int'(busy0), 1);
        rst_n = 1'b0;
        #1;
        g0r = 4; g0b = 4; g1r = 4; g1b = 4;
        m_r = 0; m_g = 0; m_b = 0;
        chk("rst_mid/busy", int'(busy0) + int'(busy1), 0);
        chk("rst_mid/upd", int'(upd0) + int'(upd1), 0);
        check_out("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(1, 1'b0, -1);
        finish_frame("post_rst", 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
